// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch port and the MEM-stage load/store port.
// One access in flight at a time; data wins contention, fetch is forced after MAX_STARVE losses.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RAM_LAT    = 1,
   parameter int MAX_STARVE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_read,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_data_out
);
   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam int LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

   state_t          state, state_nx;
   logic   [LW-1:0] lat_cnt, lat_nx;
   logic   [SW-1:0] starve_cnt, starve_nx;
   logic            owner_d;
   logic            op_we;
   logic            rvalid_q, rvalid_nx;
   logic            force_if;
   logic            d_win;

   always_comb begin
      force_if  = (starve_cnt == SW'(MAX_STARVE));
      d_win     = d_req && !(if_req && force_if);
      d_gnt     = 1'b0;
      if_gnt    = 1'b0;
      state_nx  = state;
      lat_nx    = lat_cnt;
      starve_nx = starve_cnt;
      rvalid_nx = 1'b0;
      case (state)
         IDLE: begin
            // grants are combinational, so they must also be held off while reset is asserted
            d_gnt  = reset && d_win;
            if_gnt = reset && if_req && !d_win;
            if (if_gnt)
               starve_nx = '0;
            else if (d_gnt && if_req && starve_cnt < SW'(MAX_STARVE))
               starve_nx = starve_cnt + SW'(1);
            if (d_gnt || if_gnt)
               state_nx = CMD;
         end
         CMD: begin
            if (op_we) begin
               state_nx = IDLE;
            end else if (RAM_LAT == 1) begin
               state_nx  = IDLE;
               rvalid_nx = 1'b1;
            end else begin
               state_nx = WAIT;
               lat_nx   = LW'(RAM_LAT - 1);
            end
         end
         WAIT: begin
            // lat_cnt counts the WAIT cycles left before data appears on ram_data_out
            if (lat_cnt == LW'(1)) begin
               state_nx  = IDLE;
               rvalid_nx = 1'b1;
            end else begin
               lat_nx = lat_cnt - LW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         starve_cnt  <= '0;
         rvalid_q    <= 1'b0;
         owner_d     <= 1'b0;
         op_we       <= 1'b0;
         ram_address <= '0;
         ram_data_in <= '0;
         ram_read    <= 1'b0;
         ram_write   <= 1'b0;
      end else begin
         state      <= state_nx;
         lat_cnt    <= lat_nx;
         starve_cnt <= starve_nx;
         rvalid_q   <= rvalid_nx;
         ram_read   <= 1'b0;
         ram_write  <= 1'b0;
         if (d_gnt || if_gnt) begin
            owner_d     <= d_gnt;
            op_we       <= d_gnt && d_we;
            ram_address <= d_gnt ? d_addr : if_addr;
            ram_read    <= !(d_gnt && d_we);
            ram_write   <= d_gnt && d_we;
         end
         if (d_gnt && d_we)
            ram_data_in <= d_wdata;
      end
   end

   // owner only changes at the end of a grant cycle, so it is still valid in the rvalid cycle
   assign if_rvalid = rvalid_q && !owner_d;
   assign d_rvalid  = rvalid_q && owner_d;
   assign if_rdata  = ram_data_out;
   assign d_rdata   = ram_data_out;

   a_gnt_idle : assert property (@(posedge clk) disable iff (!reset)
      (if_gnt || d_gnt) |-> (state == IDLE));
   a_one_gnt  : assert property (@(posedge clk) disable iff (!reset) !(if_gnt && d_gnt));
   a_one_strb : assert property (@(posedge clk) disable iff (!reset) !(ram_read && ram_write));
   a_one_rv   : assert property (@(posedge clk) disable iff (!reset) !(if_rvalid && d_rvalid));

endmodule
